// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel aligner: FSM encoding and default colour depth.
package vga_pkg;

  localparam int unsigned DefColorWidth = 4;
  localparam int unsigned DefFifoDepth  = 16;

  localparam logic [1:0] StWaitSof   = 2'd0;
  localparam logic [1:0] StPrimed    = 2'd1;
  localparam logic [1:0] StStreaming = 2'd2;
  localparam logic [1:0] StFlush     = 2'd3;

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a synchronous clear.
module vga_sync_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vga_pixel_aligner.sv
// Buffers a pixel stream and releases it in lock-step with the sync generator's
// active area, starting each frame on the SOF-tagged word.
module vga_pixel_aligner
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH = DefColorWidth,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter logic        SYNC_IDLE   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     active_in,
  input  logic                     frame_start_in,
  input  logic [3*COLOR_WIDTH-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     s_sof,
  output logic                     s_ready,
  input  logic                     underflow_clear,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [COLOR_WIDTH-1:0]   red,
  output logic [COLOR_WIDTH-1:0]   green,
  output logic [COLOR_WIDTH-1:0]   blue,
  output logic                     locked,
  output logic                     underflow
);

  localparam int unsigned PixW   = 3 * COLOR_WIDTH;
  localparam int unsigned EntryW = PixW + 1;

  logic [1:0]        state_q, state_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic              hsync_q, vsync_q;
  logic              underflow_q, underflow_set;
  logic              ready_int;
  logic              fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [EntryW-1:0] head;
  logic              head_sof;
  logic [PixW-1:0]   head_pix;

  assign head_sof = head[PixW];
  assign head_pix = head[PixW-1:0];

  vga_sync_fifo #(
    .WIDTH(EntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .clear(fifo_clear),
    .push (fifo_push),
    .wdata({s_sof, s_data}),
    .pop  (fifo_pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    ready_int     = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_clear    = 1'b0;
    pix_d         = '0;
    underflow_set = 1'b0;
    case (state_q)
      StWaitSof: begin
        ready_int = 1'b1;
        // Anything before the first SOF word is dropped on the floor.
        fifo_push = s_valid && s_sof;
        if (fifo_push) state_d = StPrimed;
      end
      StPrimed: begin
        ready_int = !fifo_full;
        fifo_push = s_valid && !fifo_full;
        if (frame_start_in && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StStreaming;
          if (active_in) pix_d = head_pix;
        end
      end
      StStreaming: begin
        ready_int = !fifo_full;
        fifo_push = s_valid && !fifo_full;
        if (active_in) begin
          if (fifo_empty) begin
            underflow_set = 1'b1;
            state_d       = StFlush;
          end else begin
            fifo_pop = 1'b1;
            // SOF tag and frame start must agree, otherwise the stream slipped.
            if (head_sof != frame_start_in) begin
              underflow_set = 1'b1;
              state_d       = StFlush;
            end else begin
              pix_d = head_pix;
            end
          end
        end
      end
      StFlush: begin
        fifo_clear = 1'b1;
        state_d    = StWaitSof;
      end
      default: state_d = StWaitSof;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StWaitSof;
      pix_q       <= '0;
      hsync_q     <= SYNC_IDLE;
      vsync_q     <= SYNC_IDLE;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      underflow_q <= underflow_set || (underflow_q && !underflow_clear);
    end
  end

  assign s_ready   = reset && ready_int;
  assign locked    = (state_q == StStreaming);
  assign underflow = underflow_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign red       = pix_q[PixW-1 -: COLOR_WIDTH];
  assign green     = pix_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign blue      = pix_q[COLOR_WIDTH-1:0];

endmodule

// File: doc/vga_pixel_aligner.md
VGA_PIXEL_ALIGNER -- requirements
Module: vga_pixel_aligner

Interface
REQ-001 Parameter COLOR_WIDTH, default 4: bits per colour channel.
REQ-002 Parameter FIFO_DEPTH, default 16: pixel buffer entries; SHALL be a power of two and at least 4.
REQ-003 Parameter SYNC_IDLE, default 1'b1: inactive level of hsync_out and vsync_out.
REQ-004 clock  input  1: single clock, all logic on the rising edge.
REQ-005 reset  input  1: synchronous, active-low reset.
REQ-006 hsync_in, vsync_in  input  1 each: sync levels from the sync generator.
REQ-007 active_in  input  1: the current pixel is in the visible area.
REQ-008 frame_start_in  input  1: one-cycle pulse coincident with active pixel (0,0).
REQ-009 s_data  input  3*COLOR_WIDTH: pixel, packed {R,G,B}, with R in the MSBs.
REQ-010 s_valid  input  1: s_data and s_sof are valid.
REQ-011 s_sof  input  1: this word is pixel (0,0) of a frame.
REQ-012 s_ready  output  1: the block accepts the word this cycle.
REQ-013 underflow_clear  input  1: clears the sticky underflow flag.
REQ-014 hsync_out, vsync_out  output  1 each: sync inputs delayed by exactly 1 cycle.
REQ-015 red, green, blue  output  COLOR_WIDTH each: pixel data aligned to the delayed syncs.
REQ-016 locked  output  1: high while in STREAMING.
REQ-017 underflow  output  1: sticky error flag.

Function
REQ-018 A transfer SHALL occur when s_valid && s_ready are both high; each FIFO entry SHALL store {s_sof, s_data}.
REQ-019 The state machine SHALL have four states: WAIT_SOF, PRIMED, STREAMING, FLUSH.
REQ-020 WAIT_SOF:
 - s_ready=1.
 - Non-SOF words are discarded.
 - An SOF word is written to the FIFO, then next state is PRIMED.
REQ-021 PRIMED:
 - s_ready = !full.
 - frame_start_in with the FIFO non-empty: next state STREAMING, and the head entry is popped in that same cycle.
 - frame_start_in with the FIFO empty: stay in PRIMED; the frame is output black.
REQ-022 STREAMING:
 - s_ready = !full.
 - Exactly one pop for each active_in cycle; no pop when active_in is low.
REQ-023 In STREAMING, active_in with the FIFO empty SHALL output black, set underflow, and go to FLUSH.
REQ-024 In STREAMING, popping an entry with sof=1 on a cycle where frame_start_in=0 SHALL output black, set underflow, and go to FLUSH (misalignment).
REQ-025 In STREAMING, frame_start_in with a head entry sof=0 SHALL also be treated as misalignment, handled as in REQ-024.
REQ-026 FLUSH SHALL empty the FIFO in one cycle (pointers reset) with s_ready=0, then go to WAIT_SOF.
REQ-027 Outputs SHALL be registered with 1-cycle latency:
 - red/green/blue = popped data when active_in was high and a valid pop occurred.
 - Otherwise all zero.
REQ-028 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push when full is impossible because s_ready=0.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL come from the MSB compare.
REQ-030 underflow SHALL set on any REQ-023/024/025 event, and SHALL clear only on underflow_clear or reset; if set and clear coincide, set wins.

Reset
REQ-031 While reset=0 at a clock edge:
 - state = WAIT_SOF, FIFO empty.
 - s_ready=0, locked=0, underflow=0.
 - red/green/blue = 0.
 - hsync_out = vsync_out = SYNC_IDLE.
REQ-032 s_ready SHALL be 0 during reset, and SHALL rise in the first cycle after reset deasserts.
REQ-033 A reset asserted mid-frame SHALL abandon buffered pixels with no output glitch beyond the REQ-031 values.

Structure
REQ-034 Package vga_pkg SHALL hold the state encoding constants and the default COLOR_WIDTH.
REQ-035 Buffering SHALL be a sub-module vga_sync_fifo (parameters: width, depth; one clock; synchronous clear input; full/empty outputs; first-word-fall-through read).
REQ-036 The top level SHALL hold the state machine, output registers and underflow logic; target size 150-300 RTL lines.

Verification
REQ-037 Bench SHALL cover, with COLOR_WIDTH=4 and FIFO_DEPTH=16:
 - Reset release: stream words 0x123 (sof=0), then 0x456 (sof=1) -> first discarded, second buffered; state PRIMED; locked=0.
 - Lock: prefill 0x456(sof), then 0x789, then 0xABC; pulse frame_start_in with active_in high for 3 cycles -> one cycle later RGB = 0x456, 0x789, 0xABC; locked=1.
 - Underflow: in STREAMING, the FIFO drains while active_in=1 -> RGB=0 that cycle; underflow=1; FLUSH for 1 cycle; WAIT_SOF; s_ready low exactly 1 cycle.
 - Misalignment: a sof=1 entry reaches the head mid-line -> black output; underflow=1; resync on the next SOF word; underflow_clear pulse -> underflow=0.
 - Full: hold the consumer idle and push 20 words -> s_ready=0 after 16 are accepted; a simultaneous push/pop at 15 entries keeps the count at 15.
 - Sync delay: toggle hsync_in/vsync_in every 7 cycles -> outputs match the inputs delayed by 1 cycle; after reset both outputs = 1.
